// File: rtl/contador_modulo.sv
// Parametrised modulo-N up/down counter with clock-enable prescaler, synchronous load and
// terminal-count pulse. Define CONTADOR_SATURATE_EN to saturate at the bounds instead of wrapping.
module contador_modulo #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned MODULO = 5,
  parameter int unsigned DIV    = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] S,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);

  typedef enum logic {
    ARMING  = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  run_state_t run_state;
  logic       running;
  logic       step;
  logic [WIDTH-1:0] s_next;
  logic             tc_next;

  // Reset release is taken up by one edge so the first count step lands on the second edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_state <= ARMING;
    end else begin
      run_state <= RUNNING;
    end
  end

  assign running = (run_state == RUNNING);

  generate
    if (DIV > 1) begin : g_prescaler
      localparam int unsigned PW = $clog2(DIV);
      localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

      logic [PW-1:0] presc;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          presc <= '0;
        end else if (running) begin
          if (load) begin
            presc <= '0;
          end else if (enable) begin
            presc <= (presc == PLAST) ? '0 : presc + PW'(1);
          end
        end
      end

      assign step = running && enable && !load && (presc == PLAST);
    end else begin : g_no_prescaler
      assign step = running && enable && !load;
    end
  endgenerate

  always_comb begin
    s_next  = S;
    tc_next = 1'b0;
    if (running) begin
      if (load) begin
        s_next = (load_value > TOP) ? TOP : load_value;
      end else if (step) begin
        if (up_down) begin
`ifdef CONTADOR_SATURATE_EN
          if (S != TOP) begin
            s_next  = S + WIDTH'(1);
            tc_next = (s_next == TOP);
          end
`else
          if (S == TOP) begin
            s_next  = '0;
            tc_next = 1'b1;
          end else begin
            s_next = S + WIDTH'(1);
          end
`endif
        end else begin
`ifdef CONTADOR_SATURATE_EN
          if (S != '0) begin
            s_next  = S - WIDTH'(1);
            tc_next = (s_next == '0);
          end
`else
          if (S == '0) begin
            s_next  = TOP;
            tc_next = 1'b1;
          end else begin
            s_next = S - WIDTH'(1);
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      S  <= '0;
      tc <= 1'b0;
    end else begin
      S  <= s_next;
      tc <= tc_next;
    end
  end

endmodule
